// File: rtl/uart_mem_bridge.sv
// Memory-request to UART byte-protocol master: sends cmd/addr/wdata bytes on TX, collects the reply on RX.
// Optional reply timeout is compiled in with `define UART_BRIDGE_TIMEOUT_EN.
module uart_mem_bridge #(
    parameter int unsigned TimeoutCycles = 1000000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic [7:0]  tx_tdata_o,
    output logic        tx_tvalid_o,
    input  logic        tx_tready_i,
    input  logic [7:0]  rx_tdata_i,
    input  logic        rx_tvalid_i,
    output logic        rx_tready_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_ACK, S_RDATA, S_DONE
    } state_t;

    localparam logic [7:0] CmdRead = 8'h77;
    localparam logic [7:0] AckByte = 8'hC8;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [23:0] rdata_q;
    logic        active_q;
    logic        is_write;
    logic        tx_hs;
    logic        rx_hs;
    logic        timeout_hit;

    assign is_write = |wstrb_q;
    assign tx_hs    = tx_tvalid_o & tx_tready_i;
    assign rx_hs    = rx_tready_o & rx_tvalid_i;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        tx_tvalid_o = 1'b0;
        tx_tdata_o  = 8'h00;
        rx_tready_o = 1'b0;
        mem_ready_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Held low for the first cycle out of reset so reset really drives every output to 0.
                rx_tready_o = active_q;
                if (mem_valid_i) state_d = S_CMD;
            end
            S_CMD: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = is_write ? {4'h2, wstrb_q} : CmdRead;
                if (tx_tready_i) state_d = S_ADDR;
            end
            S_ADDR: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = addr_q[{byte_cnt_q, 3'b000} +: 8];
                if (tx_tready_i && byte_cnt_q == 2'd3) state_d = is_write ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = wdata_q[{byte_cnt_q, 3'b000} +: 8];
                if (tx_tready_i && byte_cnt_q == 2'd3) state_d = S_ACK;
            end
            S_ACK: begin
                rx_tready_o = 1'b1;
                if (rx_tvalid_i || timeout_hit) state_d = S_DONE;
            end
            S_RDATA: begin
                rx_tready_o = 1'b1;
                if ((rx_tvalid_i && byte_cnt_q == 2'd3) || timeout_hit) state_d = S_DONE;
            end
            S_DONE: begin
                mem_ready_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            rdata_q     <= 24'h0;
            mem_rdata_o <= 32'h0;
            err_o       <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;

            if (state_q == S_IDLE && mem_valid_i) begin
                addr_q  <= mem_addr_i;
                wdata_q <= mem_wdata_i;
                wstrb_q <= mem_wstrb_i;
            end

            if (state_q == S_DONE) begin
                byte_cnt_q <= 2'd0;
            end else if (((state_q == S_ADDR || state_q == S_WDATA) && tx_hs) ||
                         (state_q == S_RDATA && rx_hs)) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end

            if (state_q == S_RDATA && rx_hs) begin
                if (byte_cnt_q == 2'd3) begin
                    mem_rdata_o <= {rx_tdata_i, rdata_q};
                end else begin
                    rdata_q[{byte_cnt_q, 3'b000} +: 8] <= rx_tdata_i;
                end
            end else if (state_q == S_RDATA && timeout_hit) begin
                mem_rdata_o <= 32'h0;
            end

            if ((state_q == S_IDLE && rx_hs) ||
                (state_q == S_ACK && rx_hs && rx_tdata_i != AckByte) ||
                timeout_hit) begin
                err_o <= 1'b1;
            end
        end
    end

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles) + 1;

    logic [TW-1:0] to_cnt_q;
    logic          waiting_rx;

    assign waiting_rx  = (state_q == S_RDATA || state_q == S_ACK) && !rx_tvalid_i;
    assign timeout_hit = waiting_rx && (to_cnt_q == TW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            to_cnt_q <= '0;
        end else if (waiting_rx) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0 & (TimeoutCycles == 0);
`endif

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: TX bytes and read data are scoreboarded, RX replies fed from a queue.
module tb_uart_mem_bridge;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_wdata_i = 32'h0;
    logic [3:0]  mem_wstrb_i = 4'h0;
    logic        mem_ready_o;
    logic [31:0] mem_rdata_o;
    logic [7:0]  tx_tdata_o;
    logic        tx_tvalid_o;
    logic        tx_tready_i = 1'b1;
    logic [7:0]  rx_tdata_i = 8'h00;
    logic        rx_tvalid_i = 1'b0;
    logic        rx_tready_o;
    logic        err_o;

    logic [7:0]  exp_tx[$];
    logic [7:0]  rx_pending[$];
    logic [31:0] exp_rd[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          stall_mode = 1'b0;
    bit          rx_hs_seen = 1'b0;

    uart_mem_bridge #(.TimeoutCycles(16)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .mem_valid_i (mem_valid_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wstrb_i (mem_wstrb_i),
        .mem_ready_o (mem_ready_o),
        .mem_rdata_o (mem_rdata_o),
        .tx_tdata_o  (tx_tdata_o),
        .tx_tvalid_o (tx_tvalid_o),
        .tx_tready_i (tx_tready_i),
        .rx_tdata_i  (rx_tdata_i),
        .rx_tvalid_i (rx_tvalid_i),
        .rx_tready_o (rx_tready_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // TX monitor: every valid byte, stalled or not, must equal the head of the scoreboard.
    always @(negedge clk_i) begin
        rx_hs_seen = rx_tvalid_i && rx_tready_o;
        if (tx_tvalid_o) begin
            check("tx_rx_exclusive", {31'h0, rx_tready_o}, 32'h0);
            if (exp_tx.size() == 0) begin
                check("tx_extra_valid", {31'h0, tx_tvalid_o}, 32'h0);
            end else begin
                check(tx_tready_i ? "tx_byte" : "tx_stall_hold", {24'h0, tx_tdata_o}, {24'h0, exp_tx[0]});
                if (tx_tready_i) void'(exp_tx.pop_front());
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        tx_tready_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Reply feeder: bytes go out only once the request has been fully transmitted.
    always @(posedge clk_i) begin
        #2;
        if (rx_hs_seen && rx_pending.size() > 0) void'(rx_pending.pop_front());
        if (exp_tx.size() == 0 && rx_pending.size() > 0) begin
            rx_tvalid_i = 1'b1;
            rx_tdata_i  = rx_pending[0];
        end else begin
            rx_tvalid_i = 1'b0;
            rx_tdata_i  = 8'h00;
        end
    end

    task automatic start_req(input logic [31:0] a, input logic [31:0] w,
                             input logic [3:0] s, input logic [31:0] rd);
        exp_tx.push_back(s == 4'h0 ? 8'h77 : {4'h2, s});
        for (int i = 0; i < 4; i++) exp_tx.push_back(a[8*i +: 8]);
        if (s != 4'h0) begin
            for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
        end else begin
            exp_rd.push_back(rd);
        end
        mem_addr_i  = a;
        mem_wdata_i = w;
        mem_wstrb_i = s;
        mem_valid_i = 1'b1;
    endtask

    task automatic push_reply(input logic [31:0] word, input int nbytes);
        for (int i = 0; i < nbytes; i++) rx_pending.push_back(word[8*i +: 8]);
    endtask

    task automatic finish_req(input string tag, input int exp_lat);
        int n = 0;
        bit seen = 1'b0;
        bit is_read = (mem_wstrb_i == 4'h0);
        while (!seen && n < 3000) begin
            @(negedge clk_i);
            n++;
            seen = mem_ready_o;
        end
        mem_valid_i = 1'b0;
        check({tag, "_ready_seen"}, {31'h0, seen}, 32'h1);
        if (exp_lat > 0) check({tag, "_latency"}, n, exp_lat);
        if (is_read && exp_rd.size() > 0) check({tag, "_rdata"}, mem_rdata_o, exp_rd.pop_front());
        check({tag, "_tx_drained"}, exp_tx.size(), 0);
        @(negedge clk_i);
        check({tag, "_ready_pulse"}, {31'h0, mem_ready_o}, 32'h0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int guard;
        repeat (2) @(negedge clk_i);
        check("reset_ctrl", {20'h0, mem_ready_o, tx_tvalid_o, rx_tready_o, err_o, tx_tdata_o}, 32'h0);
        check("reset_rdata", mem_rdata_o, 32'h0);
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        start_req(32'h0000_0100, 32'h0, 4'b0000, 32'hDEAD_BEEF);
        push_reply(32'hDEAD_BEEF, 4);
        finish_req("rd_basic", 11);
        check("rd_basic_err", {31'h0, err_o}, 32'h0);

        start_req(32'h0001_8004, 32'h1234_5678, 4'b0011, 32'h0);
        push_reply(32'h0000_00C8, 1);
        finish_req("wr_basic", 12);
        check("wr_basic_err", {31'h0, err_o}, 32'h0);

        stall_mode = 1'b1;
        start_req(32'h0000_FFFC, 32'h0, 4'b0000, 32'h4433_2211);
        push_reply(32'h4433_2211, 4);
        finish_req("rd_stall", 0);
        stall_mode = 1'b0;
        check("rd_stall_err", {31'h0, err_o}, 32'h0);

        start_req(32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 32'h0);
        push_reply(32'h0000_0000, 1);
        finish_req("wr_badack", 12);
        check("wr_badack_err", {31'h0, err_o}, 32'h1);

        start_req(32'h0000_0200, 32'h0, 4'b0000, 32'h0102_0304);
        push_reply(32'h0102_0304, 4);
        finish_req("rd_after_err", 11);
        check("err_sticky", {31'h0, err_o}, 32'h1);

        start_req(32'h0000_0300, 32'h0, 4'b0000, 32'h0);
        guard = 0;
        while (exp_tx.size() > 2 && guard < 200) begin
            @(negedge clk_i); #1;
            guard++;
        end
        check("mid_reset_reached", {31'h0, exp_tx.size() <= 2}, 32'h1);
        @(posedge clk_i); #2;
        reset_ni = 1'b0;
        #1;
        check("mid_reset_ctrl", {20'h0, mem_ready_o, tx_tvalid_o, rx_tready_o, err_o, tx_tdata_o}, 32'h0);
        check("mid_reset_rdata", mem_rdata_o, 32'h0);
        exp_tx.delete();
        exp_rd.delete();
        rx_pending.delete();
        mem_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        start_req(32'h0000_0008, 32'h0, 4'b0000, 32'hDDCC_BBAA);
        push_reply(32'hDDCC_BBAA, 4);
        finish_req("rd_post_reset", 11);
        check("rd_post_reset_err", {31'h0, err_o}, 32'h0);

        rx_pending.push_back(8'h55);
        repeat (4) @(negedge clk_i);
        check("stray_rx_err", {31'h0, err_o}, 32'h1);
        check("stray_rx_consumed", rx_pending.size(), 0);
        @(posedge clk_i); #1;

`ifdef UART_BRIDGE_TIMEOUT_EN
        start_req(32'h0000_0010, 32'h0, 4'b0000, 32'h0);
        finish_req("rd_timeout", 23);
        check("rd_timeout_err", {31'h0, err_o}, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
